uart_plot_rx: RTL and testbench

//  UART receiver plus line parser; the receive-side counterpart of the plotter telemetry sender.

---
 rtl/uart_plot_rx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_plot_rx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_plot_rx.sv
// 8N1 UART receiver followed by a parser for "{plotter:DD,DD}\r\n" telemetry lines.
// Raw bytes and parsed fields are both published with one-cycle strobes.
module uart_plot_rx #(
  parameter int CLK_FRE   = 50,
  parameter int UART_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic [6:0] val0,
  output logic [6:0] val1,
  output logic       val_valid,
  output logic       parse_err
);

  localparam int BIT_CNT  = CLK_FRE * 1000000 / UART_RATE;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = $clog2(BIT_CNT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;

  localparam logic [3:0] P_IDLE  = 4'd0;
  localparam logic [3:0] P_LIT   = 4'd1;
  localparam logic [3:0] P_T0    = 4'd2;
  localparam logic [3:0] P_U0    = 4'd3;
  localparam logic [3:0] P_COMMA = 4'd4;
  localparam logic [3:0] P_T1    = 4'd5;
  localparam logic [3:0] P_U1    = 4'd6;
  localparam logic [3:0] P_RBRC  = 4'd7;
  localparam logic [3:0] P_CR    = 4'd8;
  localparam logic [3:0] P_LF    = 4'd9;

  logic          rx_meta_reg, rxs_reg, rxs_d_reg;
  logic [2:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;

  logic [3:0]    pstate_reg;
  logic [2:0]    lit_idx_reg;
  logic [3:0]    tens_reg;
  logic [6:0]    stage0_reg, stage1_reg;
  logic          byte_ok;
  logic          is_digit;

  function automatic logic [7:0] lit_char(input logic [2:0] idx);
    case (idx)
      3'd0: lit_char = "p";
      3'd1: lit_char = "l";
      3'd2: lit_char = "o";
      3'd3: lit_char = "t";
      3'd4: lit_char = "t";
      3'd5: lit_char = "e";
      3'd6: lit_char = "r";
      default: lit_char = ":";
    endcase
  endfunction

  // tens*10 + units as shifts; 9*10+9 = 99 fits in 7 bits
  function automatic logic [6:0] calc_val(input logic [3:0] t, input logic [3:0] u);
    calc_val = ({3'b000, t} << 3) + ({3'b000, t} << 1) + {3'b000, u};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg  <= 1'b1;
      rxs_reg      <= 1'b1;
      rxs_d_reg    <= 1'b1;
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_meta_reg  <= uart_rx;
      rxs_reg      <= rx_meta_reg;
      rxs_d_reg    <= rxs_reg;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (rxs_d_reg && !rxs_reg) begin
            state_reg <= S_START;
            cnt_reg   <= '0;
          end
        end
        S_START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            state_reg   <= rxs_reg ? S_IDLE : S_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rxs_reg, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) state_reg <= S_STOP;
            else bit_idx_reg <= bit_idx_reg + 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            if (rxs_reg) begin
              rx_data   <= shift_reg;
              rx_valid  <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state_reg    <= S_WAIT_HI;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_WAIT_HI: if (rxs_reg) state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    is_digit = (rx_data >= "0") && (rx_data <= "9");
    byte_ok  = 1'b0;
    case (pstate_reg)
      P_LIT:   byte_ok = (rx_data == lit_char(lit_idx_reg));
      P_T0, P_U0, P_T1, P_U1: byte_ok = is_digit;
      P_COMMA: byte_ok = (rx_data == ",");
      P_RBRC:  byte_ok = (rx_data == "}");
      P_CR:    byte_ok = (rx_data == 8'h0d);
      P_LF:    byte_ok = (rx_data == 8'h0a);
      default: byte_ok = 1'b0;
    endcase
  end

  // Parser consumes the registered byte strobes, so results land one cycle after rx_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate_reg  <= P_IDLE;
      lit_idx_reg <= '0;
      tens_reg    <= '0;
      stage0_reg  <= '0;
      stage1_reg  <= '0;
      val0        <= '0;
      val1        <= '0;
      val_valid   <= 1'b0;
      parse_err   <= 1'b0;
    end else begin
      val_valid <= 1'b0;
      parse_err <= 1'b0;
      if (rx_frame_err) begin
        if (pstate_reg != P_IDLE) begin
          parse_err  <= 1'b1;
          pstate_reg <= P_IDLE;
        end
      end else if (rx_valid) begin
        if (pstate_reg == P_IDLE) begin
          if (rx_data == "{") begin
            pstate_reg  <= P_LIT;
            lit_idx_reg <= '0;
          end
        end else if (byte_ok) begin
          case (pstate_reg)
            P_LIT: begin
              if (lit_idx_reg == 3'd7) pstate_reg <= P_T0;
              else lit_idx_reg <= lit_idx_reg + 1'b1;
            end
            P_T0:    begin tens_reg <= rx_data[3:0]; pstate_reg <= P_U0; end
            P_U0:    begin stage0_reg <= calc_val(tens_reg, rx_data[3:0]); pstate_reg <= P_COMMA; end
            P_COMMA: pstate_reg <= P_T1;
            P_T1:    begin tens_reg <= rx_data[3:0]; pstate_reg <= P_U1; end
            P_U1:    begin stage1_reg <= calc_val(tens_reg, rx_data[3:0]); pstate_reg <= P_RBRC; end
            P_RBRC:  pstate_reg <= P_CR;
            P_CR:    pstate_reg <= P_LF;
            default: begin
              val0       <= stage0_reg;
              val1       <= stage1_reg;
              val_valid  <= 1'b1;
              pstate_reg <= P_IDLE;
            end
          endcase
        end else begin
          parse_err <= 1'b1;
          if (rx_data == "{") begin
            pstate_reg  <= P_LIT;
            lit_idx_reg <= '0;
          end else begin
            pstate_reg <= P_IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_plot_rx.sv
// Bench for uart_plot_rx: serial driver, line-template reference model, event scoreboard.
// Baud is scaled to 16 clocks per bit so the whole run stays short.
module tb_uart_plot_rx;

  localparam int CLK_FRE   = 100;
  localparam int UART_RATE = 6_250_000;
  localparam int B         = 16;

  localparam int K_RX = 0, K_FERR = 1, K_VAL = 2, K_PERR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, val_valid, parse_err;
  logic [6:0] val0, val1;

  uart_plot_rx #(.CLK_FRE(CLK_FRE), .UART_RATE(UART_RATE)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .val0(val0), .val1(val1), .val_valid(val_valid), .parse_err(parse_err)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int data; int v0; int v1; } ev_t;
  ev_t q[$];

  int tests = 0, fails = 0;
  int cyc = 0;
  int t_start = 0;
  int exp_v0 = 0, exp_v1 = 0, exp_rxd = 0;
  int n_rxv = 0, n_ferr = 0, n_val = 0, n_perr = 0;

  // reference model: how many characters of the line template have matched so far
  string      tmpl = "{plotter:DD,DD}\r\n";
  int         pos = 0;
  logic [7:0] line_buf [17];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic push(input int k, input int d, input int a, input int b);
    ev_t e;
    e.kind = k; e.data = d; e.v0 = a; e.v1 = b;
    q.push_back(e);
  endtask

  function automatic bit fits(input int p, input logic [7:0] c);
    logic [7:0] t;
    t = tmpl[p];
    if (t == "D") return (c >= "0") && (c <= "9");
    return c == t;
  endfunction

  task automatic model_byte(input logic [7:0] c, input bit good);
    if (!good) begin
      push(K_FERR, 0, 0, 0);
      if (pos != 0) begin push(K_PERR, 0, 0, 0); pos = 0; end
      return;
    end
    push(K_RX, int'(c), 0, 0);
    if (pos == 0) begin
      if (c == "{") begin line_buf[0] = c; pos = 1; end
    end else if (fits(pos, c)) begin
      line_buf[pos] = c;
      pos++;
      if (pos == 17) begin
        push(K_VAL, 0,
             (int'(line_buf[9]) - 48) * 10 + (int'(line_buf[10]) - 48),
             (int'(line_buf[12]) - 48) * 10 + (int'(line_buf[13]) - 48));
        pos = 0;
      end
    end else begin
      push(K_PERR, 0, 0, 0);
      pos = (c == "{") ? 1 : 0;
    end
  endtask

  task automatic model_reset();
    q.delete();
    pos = 0; exp_v0 = 0; exp_v1 = 0; exp_rxd = 0;
  endtask

  task automatic wait_bits(input int n);
    repeat (n * B) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] c, input bit good);
    model_byte(c, good);
    uart_rx = 1'b0;
    t_start = cyc;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      uart_rx = c[i];
      wait_bits(1);
    end
    if (good) begin
      uart_rx = 1'b1;
      wait_bits(1);
    end else begin
      uart_rx = 1'b0;
      wait_bits(2);
      uart_rx = 1'b1;
      wait_bits(1);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic take(input int k, input string name);
    ev_t e;
    if (q.size() == 0) begin
      chk({"unexpected_", name}, 1, 0);
      return;
    end
    e = q.pop_front();
    chk({"kind_", name}, k, e.kind);
    if (k == K_RX && e.kind == K_RX) begin
      chk("rx_byte", int'(rx_data), e.data);
      chk("rx_latency_ok", int'((cyc - t_start) >= 9 * B && (cyc - t_start) <= 10 * B + 4), 1);
      exp_rxd = int'(rx_data);
    end
    if (k == K_VAL && e.kind == K_VAL) begin
      exp_v0 = e.v0;
      exp_v1 = e.v1;
    end
  endtask

  // Scoreboard: every strobe must match the next model event; held outputs checked each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid || rx_frame_err) chk("rx_strobe_excl", int'(rx_valid & rx_frame_err), 0);
      if (val_valid || parse_err)   chk("parse_strobe_excl", int'(val_valid & parse_err), 0);
      if (rx_valid)     begin n_rxv++;  take(K_RX, "rx_valid"); end
      if (rx_frame_err) begin n_ferr++; take(K_FERR, "rx_frame_err"); end
      if (val_valid)    begin n_val++;  take(K_VAL, "val_valid"); end
      if (parse_err)    begin n_perr++; take(K_PERR, "parse_err"); end
      chk("rx_data_hold", int'(rx_data), exp_rxd);
      chk("val0", int'(val0), exp_v0);
      chk("val1", int'(val1), exp_v1);
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_data"}, int'(rx_data), 0);
    chk({tag, "_strobes"}, int'({rx_valid, rx_frame_err, val_valid, parse_err}), 0);
    chk({tag, "_val0"}, int'(val0), 0);
    chk({tag, "_val1"}, int'(val1), 0);
  endtask

  int s_rxv, s_ferr, s_val, s_perr;
  task automatic snap();
    s_rxv = n_rxv; s_ferr = n_ferr; s_val = n_val; s_perr = n_perr;
  endtask

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    wait_bits(1);

    // single byte
    snap();
    send_byte(8'h55, 1'b1);
    chk("t1_rx_count", n_rxv - s_rxv, 1);
    chk("t1_rx_data", int'(rx_data), 'h55);
    chk("t1_other", (n_ferr - s_ferr) + (n_val - s_val) + (n_perr - s_perr), 0);

    // clean line
    snap();
    send_str("{plotter:42,07}\r\n");
    wait_bits(1);
    chk("t2_rx_count", n_rxv - s_rxv, 17);
    chk("t2_val_count", n_val - s_val, 1);
    chk("t2_val0", int'(val0), 42);
    chk("t2_val1", int'(val1), 7);
    chk("t2_perr", n_perr - s_perr, 0);

    // framing error then good byte
    snap();
    send_byte(8'hA3, 1'b0);
    send_byte(8'h31, 1'b1);
    chk("t3_ferr", n_ferr - s_ferr, 1);
    chk("t3_rx_count", n_rxv - s_rxv, 1);
    chk("t3_rx_data", int'(rx_data), 'h31);

    // short low glitch
    snap();
    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 uart_rx = 1'b1;
    wait_bits(2);
    chk("t4_glitch_rx", n_rxv - s_rxv, 0);
    chk("t4_glitch_ferr", n_ferr - s_ferr, 0);
    send_byte(8'h5A, 1'b1);
    chk("t4_after_rx", int'(rx_data), 'h5A);

    // resync on '{', then aborted line keeps old values
    snap();
    send_str("{plo{plotter:12,34}\r\n");
    wait_bits(1);
    chk("t5_perr", n_perr - s_perr, 1);
    chk("t5_val_count", n_val - s_val, 1);
    chk("t5_val0", int'(val0), 12);
    chk("t5_val1", int'(val1), 34);
    snap();
    send_str("{plotter:9x,01}\r\n");
    wait_bits(1);
    chk("t5b_perr", n_perr - s_perr, 1);
    chk("t5b_val_count", n_val - s_val, 0);
    chk("t5b_val0", int'(val0), 12);
    chk("t5b_val1", int'(val1), 34);

    // reset in the middle of data bit 4
    uart_rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 4; i++) begin
      uart_rx = (i % 2 == 0);
      wait_bits(1);
    end
    uart_rx = 1'b1;
    repeat (B / 2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk_all_zero("t6_reset");
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    snap();
    send_str("{plotter:99,00}\r\n");
    wait_bits(1);
    chk("t6_val_count", n_val - s_val, 1);
    chk("t6_val0", int'(val0), 99);
    chk("t6_val1", int'(val1), 0);

    // randomized lines with garbage, corruption and framing errors
    for (int k = 0; k < 8; k++) begin
      int ng, a, b, mode, p;
      string line;
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) send_byte(8'($urandom_range(0, 255)), 1'b1);
      a = $urandom_range(0, 99);
      b = $urandom_range(0, 99);
      line = $sformatf("{plotter:%02d,%02d}\r\n", a, b);
      mode = $urandom_range(0, 3);
      p = $urandom_range(0, 16);
      for (int i = 0; i < line.len(); i++) begin
        if (mode == 1 && i == p) send_byte(8'($urandom_range(0, 255)), 1'b0);
        if (mode == 0 && i == p) send_byte(8'($urandom_range(0, 255)), 1'b1);
        else send_byte(line[i], 1'b1);
      end
    end

    wait_bits(2);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
